// File: rtl/serial_sub8.sv
// rtl/serial_sub8.sv - digit-serial ripple-borrow subtractor, Diff = A - B (optional macro SERIAL_SUB_BIN_EN adds a Bin input)
module serial_sub8 #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             Bin,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // A slice width that does not tile the operand cannot produce a correct result.
  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_sub8: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_v;
  logic             r_busy;
  logic             r_done;

  logic             w_bin;
  logic [DIGIT:0]   w_slice;
  logic [WIDTH-1:0] w_res_next;
  logic             w_v;

`ifdef SERIAL_SUB_BIN_EN
  assign w_bin = Bin;
`else
  assign w_bin = 1'b0;
`endif

  // Low slice of each operand minus the running borrow; the top bit is the borrow out.
  assign w_slice = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, r_borrow};

  // New difference slice enters at the MSB end so the LSB slice lands at bit 0 after N steps.
  generate
    if (N > 1) begin : g_shift
      assign w_res_next = {w_slice[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign w_res_next = w_slice[DIGIT-1:0];
    end
  endgenerate

  // Signed overflow only possible when operand signs differ; judged on the latched operands.
  assign w_v = (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

  // Control FSM plus operand/result datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_res    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_v      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_a_msb  <= A[WIDTH-1];
            r_b_msb  <= B[WIDTH-1];
            r_borrow <= w_bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_res    <= w_res_next;
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_borrow <= w_slice[DIGIT];
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_diff  <= w_res_next;
            r_bout  <= w_slice[DIGIT];
            r_v     <= w_v;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Diff = r_diff;
  assign Bout = r_bout;
  assign V    = r_v;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_sub8.sv
// tb/tb_serial_sub8.sv - self-checking bench for serial_sub8 (DIGIT=1 and DIGIT=4 instances)
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1, s4;
  logic [7:0] a1, b1, a4, b4;
  logic [7:0] d1, d4;
  logic       bo1, bo4, v1, v4, busy1, busy4, done1, done4;
`ifdef SERIAL_SUB_BIN_EN
  logic       bin1, bin4;
`endif

  int n_pass  = 0;
  int n_total = 0;

  serial_sub8 #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(s1),
`ifdef SERIAL_SUB_BIN_EN
    .Bin(bin1),
`endif
    .A(a1), .B(b1), .Diff(d1), .Bout(bo1), .V(v1), .busy(busy1), .done(done1)
  );

  serial_sub8 #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(s4),
`ifdef SERIAL_SUB_BIN_EN
    .Bin(bin4),
`endif
    .A(a4), .B(b4), .Diff(d4), .Bout(bo4), .V(v4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] diff, output logic bout, output logic v);
    int ur, sa, sb, sr;
    ur   = int'(a) - int'(b) - int'(bi);
    diff = 8'(ur & 255);
    bout = (ur < 0);
    sa   = a[7] ? int'(a) - 256 : int'(a);
    sb   = b[7] ? int'(b) - 256 : int'(b);
    sr   = sa - sb - int'(bi);
    v    = (sr < -128) || (sr > 127);
  endtask

  function automatic logic [10:0] outs(input int w);
    return (w == 1) ? {d4, bo4, v4, busy4} : {d1, bo1, v1, busy1};
  endfunction

  function automatic logic dn(input int w);
    return (w == 1) ? done4 : done1;
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    if (w == 1) begin
      s4 = st; a4 = a; b4 = b;
`ifdef SERIAL_SUB_BIN_EN
      bin4 = bi;
`endif
    end else begin
      s1 = st; a1 = a; b1 = b;
`ifdef SERIAL_SUB_BIN_EN
      bin1 = bi;
`endif
    end
  endtask

  // One operation starting in the current cycle; returns in the done cycle.
  // inj>0 pulses start with A=FF,B=00 during that RUN cycle (must be ignored).
  task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi,
                    input int inj, input string tag);
    logic [7:0]  ed, prev;
    logic        eb, ev;
    logic [10:0] o;
    int          n, busy_cnt, done_cnt;
    n = (w == 1) ? 2 : 8;
    model(a, b, bi, ed, eb, ev);
    o    = outs(w);
    prev = o[10:3];
    drive(w, 1'b1, a, b, bi);
    tick;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= n; c++) begin
      o = outs(w);
      if (c == 1) begin
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        chk({tag, "_hold_diff"}, o[10:3], prev);
      end
      busy_cnt += int'(o[0]);
      done_cnt += int'(dn(w));
      if (c == inj) drive(w, 1'b1, 8'hFF, 8'h00, 1'b0);
      tick;
      if (c == inj) drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    end
    o = outs(w);
    chk({tag, "_busy_cycles"}, busy_cnt, n);
    chk({tag, "_done_early"}, done_cnt, 0);
    chk({tag, "_done"}, dn(w), 1'b1);
    chk({tag, "_busy_in_done"}, o[0], 1'b0);
    chk({tag, "_diff"}, o[10:3], ed);
    chk({tag, "_bout"}, o[2], eb);
    chk({tag, "_v"}, o[1], ev);
  endtask

  initial begin
    int         dcnt;
    logic [7:0] ra, rb;
    logic       rbi;
    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    chk("rst_diff", d1, 8'h00);
    chk("rst_bout", bo1, 1'b0);
    chk("rst_v", v1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_diff4", d4, 8'h00);

    op(0, 8'h5A, 8'h23, 1'b0, 0, "t5a_23");
    tick;
    chk("done_one_cycle", done1, 1'b0);
    op(0, 8'h10, 8'h20, 1'b0, 0, "t10_20");
    tick;
    op(0, 8'h80, 8'h01, 1'b0, 0, "t80_01");
    tick;
    op(0, 8'h7F, 8'hFF, 1'b0, 0, "t7f_ff");
    op(0, 8'h01, 8'h01, 1'b0, 0, "b2b_01_01");
    tick;
    op(0, 8'h40, 8'h01, 1'b0, 3, "ignore_start");
    tick;

    op(1, 8'h00, 8'h01, 1'b0, 0, "d4_00_01");
    tick;

`ifdef SERIAL_SUB_BIN_EN
    op(0, 8'h00, 8'h00, 1'b1, 0, "bin1");
    tick;
    op(0, 8'h00, 8'h00, 1'b0, 0, "bin0");
    tick;
`endif

    for (int i = 0; i < 24; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
`ifdef SERIAL_SUB_BIN_EN
      rbi = 1'($urandom);
`else
      rbi = 1'b0;
`endif
      op(i % 3 == 2 ? 1 : 0, ra, rb, rbi, 0, "rnd");
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;

    // Reset in cycle 4 of a run aborts it with no done.
    drive(0, 1'b1, 8'h40, 8'h01, 1'b0);
    tick;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_busy", busy1, 1'b0);
    chk("abort_diff", d1, 8'h00);
    dcnt = int'(done1);
    for (int c = 0; c < 12; c++) begin
      tick;
      dcnt += int'(done1);
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_diff_held", d1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
